// File: rtl/rv32_imm_gen_pipe_pkg.sv
// Shared types for the RV32 immediate generator: per-lane format codes and instruction word.
package rv32_types;

   localparam int unsigned TYPE_W = 3;

   typedef logic [31:0] rv32_instr_t;

   typedef enum logic [TYPE_W-1:0] {
      RV32_TYPE_R = 3'd0,
      RV32_TYPE_I = 3'd1,
      RV32_TYPE_S = 3'd2,
      RV32_TYPE_B = 3'd3,
      RV32_TYPE_U = 3'd4,
      RV32_TYPE_J = 3'd5,
      RV32_TYPE_Z = 3'd6
   } rv32_type_enum_t;

endpackage

// File: rtl/rv32_imm_gen_pipe_lane.sv
// Combinational single-lane immediate decoder; sign/zero-extends the selected field to XLEN.
module rv32_imm_gen_lane
   import rv32_types::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter bit          BJ_LSB_ZERO = 1'b1
) (
   input  rv32_instr_t       instr_i,
   input  logic [TYPE_W-1:0] type_i,
   output logic [XLEN-1:0]   imm_o
);

   logic signed [11:0] i_fld, s_fld, b_fld;
   logic signed [19:0] j_fld;
   logic signed [31:0] u_fld;
   logic [XLEN-1:0]    b_ext, j_ext;
   logic               unused_opcode;

   assign i_fld = instr_i[31:20];
   assign s_fld = {instr_i[31:25], instr_i[11:7]};
   assign b_fld = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
   assign j_fld = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]};
   assign u_fld = {instr_i[31:12], 12'b0};

   // Signed size casts carry the sign bit up to XLEN.
   assign b_ext = XLEN'(b_fld);
   assign j_ext = XLEN'(j_fld);

   assign unused_opcode = ^instr_i[6:0];

   always_comb begin
      imm_o = '0;
      case (type_i)
         RV32_TYPE_I: imm_o = XLEN'(i_fld);
         RV32_TYPE_S: imm_o = XLEN'(s_fld);
         RV32_TYPE_B: imm_o = BJ_LSB_ZERO ? (b_ext << 1) : b_ext;
         RV32_TYPE_J: imm_o = BJ_LSB_ZERO ? (j_ext << 1) : j_ext;
         RV32_TYPE_U: imm_o = XLEN'(u_fld);
         RV32_TYPE_Z: imm_o = XLEN'(instr_i[19:15]);
         default:     imm_o = '0;
      endcase
   end

endmodule

// File: rtl/rv32_imm_gen_pipe.sv
// Multi-lane pipelined immediate generator with valid/ready handshake and a one-beat skid register.
module rv32_imm_gen_pipe
   import rv32_types::*;
#(
   parameter int unsigned NUM_LANES   = 1,
   parameter int unsigned XLEN        = 32,
   parameter int unsigned TAG_W       = 32,
   parameter bit          BJ_LSB_ZERO = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_LANES*32-1:0]     in_instr,
   input  logic [NUM_LANES*TYPE_W-1:0] in_type,
   input  logic [TAG_W-1:0]            in_tag,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUM_LANES*XLEN-1:0]   out_imm,
   output logic [TAG_W-1:0]            out_tag
);

   logic [NUM_LANES*XLEN-1:0] dec_imm;
   logic                      main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic [NUM_LANES*XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
   logic [TAG_W-1:0]          main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
   logic                      in_ready_q, in_ready_d;
   logic                      in_xfer, out_xfer;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      rv32_imm_gen_lane #(
         .XLEN        (XLEN),
         .BJ_LSB_ZERO (BJ_LSB_ZERO)
      ) u_lane (
         .instr_i (in_instr[32*k +: 32]),
         .type_i  (in_type[TYPE_W*k +: TYPE_W]),
         .imm_o   (dec_imm[XLEN*k +: XLEN])
      );
   end

   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = main_vld_q && out_ready;

   // Skid only fills while main is full and not draining, so a full skid implies a full main.
   always_comb begin
      main_vld_d = main_vld_q;
      main_imm_d = main_imm_q;
      main_tag_d = main_tag_q;
      skid_vld_d = skid_vld_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (skid_vld_q) begin
         if (out_xfer) begin
            main_imm_d = skid_imm_q;
            main_tag_d = skid_tag_q;
            skid_vld_d = 1'b0;
         end
      end else if (in_xfer && (!main_vld_q || out_xfer)) begin
         main_vld_d = 1'b1;
         main_imm_d = dec_imm;
         main_tag_d = in_tag;
      end else if (in_xfer) begin
         skid_vld_d = 1'b1;
         skid_imm_d = dec_imm;
         skid_tag_d = in_tag;
      end else if (out_xfer) begin
         main_vld_d = 1'b0;
      end
      in_ready_d = !skid_vld_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld_q <= 1'b0;
         main_imm_q <= '0;
         main_tag_q <= '0;
         skid_vld_q <= 1'b0;
         skid_imm_q <= '0;
         skid_tag_q <= '0;
         in_ready_q <= 1'b0;
      end else begin
         main_vld_q <= main_vld_d;
         main_imm_q <= main_imm_d;
         main_tag_q <= main_tag_d;
         skid_vld_q <= skid_vld_d;
         skid_imm_q <= skid_imm_d;
         skid_tag_q <= skid_tag_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_vld_q;
   assign out_imm   = main_imm_q;
   assign out_tag   = main_tag_q;

endmodule

// File: tb/tb_rv32_imm_gen_pipe.sv
// Self-checking bench: two-lane 32-bit (byte-offset B/J) and 64-bit (halfword B/J) instances vs. a FIFO reference model.
module tb_rv32_imm_gen_pipe;
   import rv32_types::*;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, out_ready;
   logic [63:0]   in_instr;
   logic [5:0]    in_type;
   logic [31:0]   in_tag;
   logic          in_ready, out_valid, in_ready64, out_valid64;
   logic [63:0]   out_imm;
   logic [127:0]  out_imm64;
   logic [31:0]   out_tag, out_tag64;

   int checks = 0;
   int errors = 0;
   int n_out  = 0;
   bit chk_en = 1'b0;

   typedef struct {
      logic [63:0] instr;
      logic [5:0]  typ;
      logic [31:0] tag;
   } beat_t;
   beat_t q[$];

   always #5 clk = ~clk;

   rv32_imm_gen_pipe #(
      .NUM_LANES (2), .XLEN (32), .TAG_W (32), .BJ_LSB_ZERO (1'b1)
   ) dut (
      .clk (clk), .rst_n (rst_n), .flush (flush), .in_valid (in_valid), .in_ready (in_ready),
      .in_instr (in_instr), .in_type (in_type), .in_tag (in_tag),
      .out_valid (out_valid), .out_ready (out_ready), .out_imm (out_imm), .out_tag (out_tag)
   );

   rv32_imm_gen_pipe #(
      .NUM_LANES (2), .XLEN (64), .TAG_W (32), .BJ_LSB_ZERO (1'b0)
   ) dut64 (
      .clk (clk), .rst_n (rst_n), .flush (flush), .in_valid (in_valid), .in_ready (in_ready64),
      .in_instr (in_instr), .in_type (in_type), .in_tag (in_tag),
      .out_valid (out_valid64), .out_ready (out_ready), .out_imm (out_imm64), .out_tag (out_tag64)
   );

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Field value = sign weight (s = 0 or -1) plus positional weights of the scattered bits.
   function automatic longint ref_imm(input logic [31:0] ins, input logic [2:0] t, input bit bjz);
      longint s, a, b, c, v;
      s = ins[31] ? -64'sd1 : 64'sd0;
      v = 0;
      case (t)
         RV32_TYPE_I: begin a = ins[30:20]; v = s * 2048 + a; end
         RV32_TYPE_S: begin a = ins[30:25]; b = ins[11:7]; v = s * 2048 + a * 32 + b; end
         RV32_TYPE_B: begin
            a = ins[7]; b = ins[30:25]; c = ins[11:8];
            v = s * 2048 + a * 1024 + b * 16 + c;
            if (bjz) v = v * 2;
         end
         RV32_TYPE_J: begin
            a = ins[19:12]; b = ins[20]; c = ins[30:21];
            v = s * 524288 + a * 2048 + b * 1024 + c;
            if (bjz) v = v * 2;
         end
         RV32_TYPE_U: begin a = ins[30:12]; v = s * 64'sh8000_0000 + a * 4096; end
         RV32_TYPE_Z: begin a = ins[19:15]; v = a; end
         default:     v = 0;
      endcase
      return v;
   endfunction

   function automatic logic [63:0] exp32(input beat_t bt);
      logic [63:0] r, v;
      for (int k = 0; k < 2; k++) begin
         v = ref_imm(bt.instr[32*k +: 32], bt.typ[3*k +: 3], 1'b1);
         r[32*k +: 32] = v[31:0];
      end
      return r;
   endfunction

   function automatic logic [127:0] exp64(input beat_t bt);
      logic [127:0] r;
      for (int k = 0; k < 2; k++)
         r[64*k +: 64] = ref_imm(bt.instr[32*k +: 32], bt.typ[3*k +: 3], 1'b0);
      return r;
   endfunction

   // Model state is compared before applying this cycle's transfers.
   always @(negedge clk) begin
      beat_t nb;
      if (chk_en) begin
         chk("out_valid", out_valid, q.size() != 0);
         chk("out_valid64", out_valid64, q.size() != 0);
         chk("in_ready", in_ready, q.size() < 2);
         if (q.size() != 0) begin
            chk("out_imm32", out_imm, exp32(q[0]));
            chk("out_imm64", out_imm64, exp64(q[0]));
            chk("out_tag", out_tag, q[0].tag);
            chk("out_tag64", out_tag64, q[0].tag);
         end
         if (out_valid && out_ready && q.size() != 0) begin
            void'(q.pop_front());
            n_out++;
         end
         if (flush) q.delete();
         else if (in_valid && in_ready) begin
            nb.instr = in_instr; nb.typ = in_type; nb.tag = in_tag;
            q.push_back(nb);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] i0, input logic [2:0] t0,
                       input logic [31:0] i1, input logic [2:0] t1, input logic [31:0] tag);
      in_valid = 1'b1;
      in_instr = {i1, i0};
      in_type  = {t1, t0};
      in_tag   = tag;
      cyc();
      in_valid = 1'b0;
   endtask

   initial begin
      int  nbt, n0;
      bit  acc;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_type = '0; in_tag = '0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_imm", out_imm, 0);
      chk("rst_out_imm64", out_imm64, 0);
      chk("rst_out_tag", out_tag, 0);
      @(negedge clk); #1 rst_n = 1'b1;
      cyc();
      chk("ready_after_rst", in_ready, 1);
      chk_en = 1'b1;

      // Directed decode vectors, lane 1 decodes a different format from lane 0.
      out_ready = 1'b1;
      send(32'hFFF00093, RV32_TYPE_I, 32'h123450B7, RV32_TYPE_U, 32'd100);
      chk("i_u_valid", out_valid, 1);
      chk("i_u_imm32", out_imm, {32'h1234_5000, 32'hFFFF_FFFF});
      chk("i_u_imm64", out_imm64, {64'h0000_0000_1234_5000, 64'hFFFF_FFFF_FFFF_FFFF});
      chk("i_u_tag", out_tag, 32'd100);
      send(32'hFE112E23, RV32_TYPE_S, 32'h000F8073, RV32_TYPE_Z, 32'd101);
      chk("s_z_imm32", out_imm, {32'h0000_001F, 32'hFFFF_FFFC});
      chk("s_z_imm64", out_imm64, {64'h1F, 64'hFFFF_FFFF_FFFF_FFFC});
      send(32'hFE000EE3, RV32_TYPE_B, 32'h0010006F, RV32_TYPE_J, 32'd102);
      chk("b_j_imm32", out_imm, {32'h0000_0800, 32'hFFFF_FFFC});
      chk("b_j_imm64", out_imm64, {64'h400, 64'hFFFF_FFFF_FFFF_FFFE});
      send(32'hFFFFFFFF, RV32_TYPE_R, 32'hFFFFFFFF, 3'd7, 32'd103);
      chk("r_undef_imm32", out_imm, 64'h0);
      cyc();
      chk("idle_valid", out_valid, 0);

      // Stall for three cycles while streaming four beats.
      nbt = 0; n0 = n_out;
      for (int c = 0; c < 30; c++) begin
         out_ready = (c >= 3);
         in_valid  = (nbt < 4);
         in_instr  = {$urandom, $urandom};
         in_type   = 6'($urandom);
         in_tag    = nbt;
         acc       = in_valid && in_ready;
         if (c == 2) chk("stall_ready_low", in_ready, 0);
         cyc();
         if (acc) nbt++;
      end
      in_valid = 1'b0;
      chk("stream_sent", nbt, 4);
      chk("stream_emitted", n_out - n0, 4);

      // Flush with both registers occupied and a new beat offered.
      out_ready = 1'b0;
      send(32'hFFF00093, RV32_TYPE_I, 32'h0, RV32_TYPE_R, 32'd200);
      send(32'h123450B7, RV32_TYPE_U, 32'h0, RV32_TYPE_R, 32'd201);
      chk("held_two_ready", in_ready, 0);
      n0 = n_out;
      in_valid = 1'b1; in_tag = 32'd202; flush = 1'b1;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", out_valid, 0);
      chk("flush_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (3) cyc();
      chk("flush_nothing_out", n_out - n0, 0);

      // Asynchronous reset during a stall.
      out_ready = 1'b0;
      send(32'hFFF00093, RV32_TYPE_I, 32'hFE112E23, RV32_TYPE_S, 32'd300);
      send(32'h0010006F, RV32_TYPE_J, 32'h000F8073, RV32_TYPE_Z, 32'd301);
      #2;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_imm", out_imm, 0);
      chk("async_rst_imm64", out_imm64, 0);
      chk("async_rst_tag", out_tag, 0);
      q.delete();
      @(negedge clk); #1 rst_n = 1'b1;
      cyc();
      chk("ready_after_rst2", in_ready, 1);
      chk_en = 1'b1;

      // Random traffic with occasional flushes.
      for (int c = 0; c < 400; c++) begin
         in_valid  = $urandom_range(1, 0) == 1;
         out_ready = $urandom_range(2, 0) != 0;
         flush     = $urandom_range(24, 0) == 0;
         in_instr  = {$urandom, $urandom};
         in_type   = 6'($urandom);
         in_tag    = $urandom;
         cyc();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (4) cyc();
      chk("drained_valid", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
